// File: rtl/cla_pkg.sv
// Shared types and helpers for the serial carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // Counter width for n passes; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_cla_seq_addfour.sv
// 4-bit carry-lookahead slice: flat generate/propagate expansion, no ripple.
module addfour (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/serial_cla_seq.sv
// Multi-cycle adder: one 4-bit CLA slice reused over WIDTH/4 cycles, LS nibble first,
// with valid/ready handshakes on both sides.
module serial_cla_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int CW      = cnt_width(NIBBLES);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("serial_cla_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry_reg;
  logic               a_msb;
  logic               b_msb;
  logic               ovf_reg;
  logic [CW-1:0]      cnt;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  logic [SLICE_W-1:0]       slice_sum;
  logic                     slice_cout;
  logic [WIDTH+SLICE_W-1:0] sum_cat;
  logic                     last_pass;

  addfour u_slice (
    .a    (a_reg[SLICE_W-1:0]),
    .b    (b_reg[SLICE_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the MSB end; the concatenation also covers WIDTH == 4.
  assign sum_cat   = {slice_sum, sum_reg};
  assign last_pass = (cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      ovf_reg       <= 1'b0;
      cnt           <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            a_msb        <= a[WIDTH-1];
            b_msb        <= b[WIDTH-1];
            cnt          <= '0;
            state        <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg   <= sum_cat[WIDTH+SLICE_W-1:SLICE_W];
          a_reg     <= a_reg >> SLICE_W;
          b_reg     <= b_reg >> SLICE_W;
          carry_reg <= slice_cout;
          cnt       <= cnt + CW'(1);
          if (last_pass) begin
            // MSBs of the operands were shifted out long ago; use the captured copies.
            ovf_reg       <= a_msb ^ b_msb ^ slice_sum[SLICE_W-1] ^ slice_cout;
            state         <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign sum       = sum_reg;
  assign cout      = carry_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_serial_cla_seq.sv
// Directed bench for serial_cla_seq at WIDTH=32 and WIDTH=4.
module tb_serial_cla_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        co32, vf32, bz32;

  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, s4;
  logic        co4, vf4, bz4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_cla_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32),
    .overflow(vf32), .busy(bz32)
  );

  serial_cla_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4),
    .overflow(vf4), .busy(bz4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the operands.
  task automatic accept32(input logic [31:0] a, input logic [31:0] b, input logic c);
    iv32 = 1'b1; a32 = a; b32 = b; cin32 = c;
    @(negedge clk);
    iv32 = 1'b0;
    chk("acc_in_ready", 32'(ir32), 32'd0);
    chk("acc_busy", 32'(bz32), 32'd1);
  endtask

  task automatic await32(input string tag, input logic [31:0] es, input logic ec,
                         input logic ev);
    int lat;
    lat = 0;
    while (!ov32 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_sum"}, s32, es);
    chk({tag, "_cout"}, 32'(co32), 32'(ec));
    chk({tag, "_ovf"}, 32'(vf32), 32'(ev));
  endtask

  task automatic release32(input logic [31:0] es);
    or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
    chk("rel_out_valid", 32'(ov32), 32'd0);
    chk("rel_in_ready", 32'(ir32), 32'd1);
    chk("rel_sum_hold", s32, es);
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [31:0] es, input logic ec, input logic ev);
    accept32(a, b, c);
    await32(tag, es, ec, ev);
    release32(es);
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic c, input logic [3:0] es, input logic ec, input logic ev);
    int lat;
    iv4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    @(negedge clk);
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd1);
    chk({tag, "_sum"}, 32'(s4), 32'(es));
    chk({tag, "_cout"}, 32'(co4), 32'(ec));
    chk({tag, "_ovf"}, 32'(vf4), 32'(ev));
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    chk({tag, "_in_ready"}, 32'(ir4), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(ir32), 32'd1);
    chk("rst_out_valid", 32'(ov32), 32'd0);
    chk("rst_busy", 32'(bz32), 32'd0);
    chk("rst_sum", s32, 32'd0);
    chk("rst_cout", 32'(co32), 32'd0);
    chk("rst_ovf", 32'(vf32), 32'd0);
    chk("rst4_in_ready", 32'(ir4), 32'd1);
    chk("rst4_sum", 32'(s4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run32("basic",   32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    run32("ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run32("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run32("negovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run32("mixed",   32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 32'hDFD1_0457, 1'b0, 1'b0);
    run32("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands are presented and ignored.
    accept32(32'h0000_000A, 32'h0000_0005, 1'b0);
    await32("bp", 32'h0000_000F, 1'b0, 1'b0);
    iv32 = 1'b1; a32 = 32'h1111_1111; b32 = 32'h2222_2222; cin32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ov32), 32'd1);
      chk("bp_in_ready", 32'(ir32), 32'd0);
      chk("bp_sum", s32, 32'h0000_000F);
    end
    release32(32'h0000_000F);
    accept32(32'h1111_1111, 32'h2222_2222, 1'b0);
    await32("bp_next", 32'h3333_3333, 1'b0, 1'b0);
    release32(32'h3333_3333);

    // Abort mid-operation after four nibbles, then check for residue.
    accept32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort_pre_out_valid", 32'(ov32), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(ir32), 32'd1);
    chk("abort_out_valid", 32'(ov32), 32'd0);
    chk("abort_busy", 32'(bz32), 32'd0);
    chk("abort_sum", s32, 32'd0);
    chk("abort_cout", 32'(co32), 32'd0);
    chk("abort_ovf", 32'(vf32), 32'd0);
    run32("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    run4("w4_ovf",   4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    run4("w4_carry", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run4("w4_cin",   4'h9, 4'h9, 1'b1, 4'h3, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_cla_seq.md
Name: serial_cla_seq

Overview:
- Multi-cycle N-bit adder that time-multiplexes one 4-bit carry-lookahead slice (addfour) over WIDTH/4 cycles.
- Latches operands on a valid/ready handshake and feeds one nibble per cycle, least significant first, with the carry registered between cycles.
- Returns the sum, carry-out and signed overflow on a valid/ready output handshake.
- Area-saving alternative to the fully combinational 32-bit CLA, for non-critical arithmetic paths.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NIBBLES, WIDTH/4, derived (localparam); number of slice passes.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  output  1  unsigned carry-out.
- overflow  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, overflow=0, nibble counter=0, carry register=0, operand registers=0.
- States:
  - IDLE: in_ready=1. When in_valid=1: latch a, b into shift registers, cin into the carry register, clear the counter, go to RUN.
  - RUN: slice inputs are a_reg[3:0], b_reg[3:0] and carry_reg.
    - Each edge: shift the slice sum into sum_reg from the MSB end (sum_reg <= {slice_sum, sum_reg[WIDTH-1:4]}).
    - Same edge: shift a_reg and b_reg right by 4, load carry_reg with the slice cout, increment the counter.
    - At counter==NIBBLES-1 the edge stores the last nibble and moves to DONE.
  - DONE: out_valid=1. sum, cout (=carry_reg) and overflow stay stable until out_ready=1. On out_ready, go to IDLE.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (8 for WIDTH=32).
- Throughput: in_ready is low in RUN and DONE, so one operation every NIBBLES+2 cycles minimum. Back-to-back sequence: accept, NIBBLES RUN cycles, DONE cycle, IDLE cycle.
- Overflow = a_msb ^ b_msb ^ sum_msb ^ cout. a_msb and b_msb are captured at accept in dedicated bits, because the shift registers lose them.
- in_valid while not in IDLE: ignored, no effect on operands.
- out_ready while not in DONE: ignored.
- sum, cout and overflow are meaningful only while out_valid=1. They hold their value through IDLE until the next accept.
- rst mid-RUN or in DONE: operation aborted, result discarded, every output returns to its reset value on that edge.
- WIDTH=4: one RUN cycle. The counter is at least 1 bit wide.
- No combinational path from in_valid or out_ready to any output. All outputs are registered or decoded from state.

Decomposition:
- Shared package (cla_pkg):
  - state enum {IDLE, RUN, DONE}.
  - SLICE_W=4 constant.
  - clog2-based counter-width function.
- One sub-module: the existing addfour 4-bit CLA slice, instantiated once. No other sub-modules; the FSM and shift registers live in serial_cla_seq.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0, overflow=0.
- Basic add, WIDTH=32: a=0x0000_0001, b=0x0000_0002, cin=0 -> out_valid exactly 8 cycles after accept; sum=0x0000_0003, cout=0, overflow=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, overflow=0. Same check with a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, overflow=1.
- Output backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout and overflow stable. in_valid=1 with new operands is ignored and in_ready stays 0. Raise out_ready -> IDLE next cycle, then the new operands are accepted.
- Reset mid-operation: assert rst at RUN nibble 4 -> next cycle IDLE with all outputs at reset values. The following op a=0x1234_5678, b=0x1111_1111 gives sum=0x2345_6789 with no residue from the aborted op.
- Random regression: 1000 random a, b, cin with random out_ready stalls. Compare against a golden {cout,sum}=a+b+cin and the overflow formula. Repeat with WIDTH=4 and WIDTH=8 (latency 1 and 2).
